// File: rtl/bram_fifo_ctrl_if.sv
// rtl/bram_fifo_ctrl_if.sv - push/pop stream and RAM port bundle for bram_fifo_ctrl
interface bram_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              in_we;
  logic [DATA_W-1:0] in_data;
  logic              in_full;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W+1:0] level;
  logic              overflow;
  logic              ram_b_we;
  logic [ADDR_W-1:0] ram_b_addr;
  logic [DATA_W-1:0] ram_b_write;
  logic [ADDR_W-1:0] ram_a_addr;
  logic [DATA_W-1:0] ram_a_read;

  modport slave (
    input  in_we, in_data, out_ready, ram_a_read,
    output in_full, out_data, out_valid, level, overflow,
           ram_b_we, ram_b_addr, ram_b_write, ram_a_addr
  );

  modport master (
    output in_we, in_data, out_ready, ram_a_read,
    input  in_full, out_data, out_valid, level, overflow,
           ram_b_we, ram_b_addr, ram_b_write, ram_a_addr
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FWFT FIFO controller over a 2-port BRAM with a 2-entry output stage
module bram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  bram_fifo_ctrl_if.slave   bus
);
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic              r_pend;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_q0;
  logic [DATA_W-1:0] r_q1;
  logic              r_in_full;
  logic              r_overflow;

  logic [ADDR_W:0]   w_ram_cnt;
  logic              w_push;
  logic              w_pop;
  logic              w_avail;
  logic              w_issue;
  logic [ADDR_W:0]   w_wptr_nxt;
  logic [ADDR_W:0]   w_rptr_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic [1:0]        w_occ_nxt;
  logic [DATA_W-1:0] w_q0_nxt;
  logic [DATA_W-1:0] w_q1_nxt;

  assign w_ram_cnt  = r_wptr - r_rptr;
  assign w_push     = bus.in_we & ~r_in_full;
  assign w_pop      = (r_occ != 2'd0) & bus.out_ready;
  assign w_avail    = (w_ram_cnt != '0);
  // Read only if the word it returns is guaranteed a slot in the output stage.
  assign w_issue    = w_avail &
                      (({1'b0, r_occ} + {2'b00, r_pend}) < (3'd2 + {2'b00, w_pop}));
  assign w_wptr_nxt = r_wptr + (ADDR_W+1)'(w_push);
  assign w_rptr_nxt = r_rptr + (ADDR_W+1)'(w_issue);
  assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;

  always_comb begin
    w_q0_nxt  = r_q0;
    w_q1_nxt  = r_q1;
    w_occ_nxt = r_occ;
    if (w_pop) begin
      w_q0_nxt  = r_q1;
      w_occ_nxt = r_occ - 2'd1;
    end
    // The word read last cycle lands behind whatever survives the pop.
    if (r_pend) begin
      if (w_occ_nxt == 2'd0) begin
        w_q0_nxt = bus.ram_a_read;
      end else begin
        w_q1_nxt = bus.ram_a_read;
      end
      w_occ_nxt = w_occ_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_pend     <= 1'b0;
      r_occ      <= 2'd0;
      r_q0       <= '0;
      r_q1       <= '0;
      r_in_full  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_pend     <= w_issue;
      r_occ      <= w_occ_nxt;
      r_q0       <= w_q0_nxt;
      r_q1       <= w_q1_nxt;
      r_in_full  <= (w_cnt_nxt == DEPTH_W);
      r_overflow <= r_overflow | (bus.in_we & r_in_full);
    end
  end

  assign bus.in_full     = r_in_full;
  assign bus.overflow    = r_overflow;
  assign bus.out_valid   = (r_occ != 2'd0);
  assign bus.out_data    = r_q0;
  assign bus.level       = (ADDR_W+2)'(w_ram_cnt) + (ADDR_W+2)'(r_pend) + (ADDR_W+2)'(r_occ);
  assign bus.ram_b_we    = w_push;
  assign bus.ram_b_addr  = r_wptr[ADDR_W-1:0];
  assign bus.ram_b_write = bus.in_data;
  assign bus.ram_a_addr  = r_rptr[ADDR_W-1:0];
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - directed and random checks of bram_fifo_ctrl against a queue model
module tb_bram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_b_we) mem[bus.ram_b_addr] <= bus.ram_b_write;
    bus.ram_a_read <= mem[bus.ram_a_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] q[$];
  int   m_level = 0;
  logic m_ovf = 1'b0;
  logic hold_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_full;
  logic [ADDR_W+1:0] s_level;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, sample just after, update the model.
  task automatic step(input logic we, input logic [DATA_W-1:0] d, input logic rdy);
    logic acc, pop;
    @(negedge clk);
    reset = 1'b0;
    bus.in_we = we;
    bus.in_data = d;
    bus.out_ready = rdy;
    #1;
    s_valid = bus.out_valid;
    s_data  = bus.out_data;
    s_full  = bus.in_full;
    s_level = bus.level;
    chk("level", 32'(s_level), 32'(m_level));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (hold_prev) begin
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_data", 32'(s_data), 32'(prev_data));
    end
    acc = we & ~s_full;
    pop = s_valid & rdy;
    if (acc) chk("wr_addr_data", {bus.ram_b_we, bus.ram_b_write}, {1'b1, d});
    if (we & s_full) m_ovf = 1'b1;
    if (pop) begin
      if (q.size() == 0) chk("spurious_valid", 32'(s_valid), 32'd0);
      else begin
        chk("data", 32'(s_data), 32'(q[0]));
        void'(q.pop_front());
      end
    end
    if (acc) q.push_back(d);
    m_level = m_level + int'(acc) - int'(pop);
    hold_prev = s_valid & ~rdy;
    prev_data = s_data;
  endtask

  task automatic do_reset(input logic we);
    @(negedge clk);
    reset = 1'b1;
    bus.in_we = we;
    bus.in_data = 8'hEE;
    bus.out_ready = 1'b1;
    q.delete();
    m_level = 0;
    m_ovf = 1'b0;
    hold_prev = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_we = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state and latency of the first word
    do_reset(1'b0);
    step(1'b1, 8'h11, 1'b1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data", 32'(s_data), 32'd0);
    chk("rst_full", 32'(s_full), 32'd0);
    step(1'b1, 8'h22, 1'b1);
    chk("t1_valid_k1", 32'(s_valid), 32'd0);
    step(1'b1, 8'h33, 1'b1);
    chk("t1_valid_k2", 32'(s_valid), 32'd0);
    for (int k = 3; k <= 5; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t1_valid_stream", 32'(s_valid), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t1_empty_valid", 32'(s_valid), 32'd0);
    chk("t1_empty_level", 32'(s_level), 32'd0);

    // Fill to DEPTH+2 with the consumer stalled
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, DATA_W'(i), 1'b0);
      chk("t2_accept", 32'(s_full), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t2_full", 32'(s_full), 32'd1);
    chk("t2_level", 32'(s_level), 32'(DEPTH + 2));

    // Push while full is dropped and latches overflow
    step(1'b1, 8'hAA, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_overflow", 32'(bus.overflow), 32'd1);
    chk("t3_level", 32'(s_level), 32'(DEPTH + 2));
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t2_no_gap", 32'(s_valid), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t2_drained", 32'(s_valid), 32'd0);
    chk("t3_overflow_sticky", 32'(bus.overflow), 32'd1);

    // Streaming through pointer wrap
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, DATA_W'($urandom), 1'b1);
      chk("t4_level_le3", 32'(s_level <= 3), 32'd1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("t4_all_out", q.size(), 32'd0);

    // Random push and backpressure
    for (int i = 0; i < 400; i++)
      step(1'(($urandom % 3) != 0), DATA_W'($urandom), 1'($urandom % 2));
    for (int i = 0; i < DEPTH + 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("t5_all_out", q.size(), 32'd0);

    // Reset with words held in RAM, output stage and read pipeline
    for (int i = 0; i < 6; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0);
    step(1'b1, 8'h50, 1'b1);
    do_reset(1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_valid", 32'(s_valid), 32'd0);
    chk("t6_level", 32'(s_level), 32'd0);
    chk("t6_full", 32'(s_full), 32'd0);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_lat_k1", 32'(s_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_lat_k2", 32'(s_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_lat_k3", 32'(s_valid), 32'd1);
    chk("t6_data", 32'(s_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_empty", 32'(s_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
